// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter and its consumers.
package cdb_arbiter_pkg;

    localparam int NUM_FU = 3;

    // Unit indices, aligned with the ALU-select encoding
    localparam int ADDSUB = 0;
    localparam int MUL    = 1;
    localparam int DIV    = 2;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 16;

    // Tag value meaning "no producer"
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin priority picker: the first set request at or after i_ptr wins,
// wrapping modulo N. Reusable wherever a fair single pick is needed.
module cdb_arbiter_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the pointer, wrapping around; only the first hit is granted
    always_comb begin
        int w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry result buffer per functional unit,
// round-robin selection, registered broadcast and a contention counter.
module cdb_arbiter #(
    parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
    parameter int CNT_W  = cdb_arbiter_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [NUM_FU-1:0]        cdb_src,
    output logic [CNT_W-1:0]         contention_cnt
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] r_buf_v;
    logic [TAG_W-1:0]  r_buf_tag  [NUM_FU];
    logic [DATA_W-1:0] r_buf_data [NUM_FU];
    logic [PTR_W-1:0]  r_rr_ptr;

    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [NUM_FU-1:0] r_cdb_src;
    logic [CNT_W-1:0]  r_cnt;

    logic [NUM_FU-1:0] w_grant;
    logic [PTR_W-1:0]  w_gidx;
    logic              w_any;
    logic [NUM_FU-1:0] w_accept;
    logic              w_contend;
    logic [PTR_W-1:0]  w_ptr_next;

    cdb_arbiter_rr_pick #(
        .N     (NUM_FU),
        .IDX_W (PTR_W)
    ) u_pick (
        .i_req   (r_buf_v),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // A draining buffer can refill in the same cycle; ready depends on state only
    assign fu_ready   = ~r_buf_v | w_grant;
    assign w_accept   = fu_valid & fu_ready;
    // Clearing the lowest set bit leaves something only when two or more are set
    assign w_contend  = |(r_buf_v & (r_buf_v - NUM_FU'(1)));
    assign w_ptr_next = (w_gidx == PTR_W'(NUM_FU - 1)) ? '0 : w_gidx + PTR_W'(1);

    // Buffer occupancy: flush beats accept, accept beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_v <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (flush) begin
                    r_buf_v[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_buf_v[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Buffer payload capture; meaningful only while the matching valid bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_accept[i]) begin
                r_buf_tag[i]  <= fu_tag[i*TAG_W +: TAG_W];
                r_buf_data[i] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pointer moves past the last winner; flush restarts at unit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // Registered broadcast of the granted buffer; tag/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= TAG_W'(cdb_arbiter_pkg::TAG_NONE);
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else begin
            r_cdb_valid <= w_any && !flush;
            r_cdb_src   <= (w_any && !flush) ? w_grant : '0;
            if (w_any) begin
                r_cdb_tag  <= r_buf_tag[w_gidx];
                r_cdb_data <= r_buf_data[w_gidx];
            end
        end
    end

    // Saturating contention counter, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_contend && !flush && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cdb_valid      = r_cdb_valid;
    assign cdb_tag        = r_cdb_tag;
    assign cdb_data       = r_cdb_data;
    assign cdb_src        = r_cdb_src;
    assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter with a behavioural model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  fu_valid = '0;
    logic [11:0] fu_tag = '0;
    logic [95:0] fu_data = '0;
    logic [2:0]  fu_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  cdb_src;
    logic [15:0] contention_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state
    bit          m_v    [3];
    logic [3:0]  m_tag  [3];
    logic [31:0] m_data [3];
    int          m_ptr;
    bit          m_cv;
    logic [3:0]  m_ctag;
    logic [31:0] m_cdata;
    logic [2:0]  m_csrc;
    int          m_cnt;

    cdb_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fu_valid       (fu_valid),
        .fu_tag         (fu_tag),
        .fu_data        (fu_data),
        .fu_ready       (fu_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_src        (cdb_src),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_v[i] = 0;
        m_ptr = 0; m_cv = 0; m_ctag = '0; m_cdata = '0; m_csrc = '0; m_cnt = 0;
    endtask

    function automatic int model_winner();
        for (int k = 0; k < 3; k++)
            if (m_v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        int g;
        g = model_winner();
        for (int i = 0; i < 3; i++) r[i] = !m_v[i] || (g == i);
        return r;
    endfunction

    // Apply one clock edge worth of behaviour to the model
    task automatic model_step();
        int g, occ;
        logic [2:0] rdy;
        g   = model_winner();
        rdy = model_ready();
        occ = 0;
        for (int i = 0; i < 3; i++) occ += m_v[i];
        if (g >= 0 && !flush) begin
            m_cv = 1; m_csrc = 3'(1 << g);
        end else begin
            m_cv = 0; m_csrc = '0;
        end
        if (g >= 0) begin
            m_ctag = m_tag[g]; m_cdata = m_data[g];
        end
        if (!flush && occ >= 2 && m_cnt < 65535) m_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (flush) m_v[i] = 0;
            else if (fu_valid[i] && rdy[i]) begin
                m_v[i] = 1; m_tag[i] = fu_tag[i*4 +: 4]; m_data[i] = fu_data[i*32 +: 32];
            end else if (g == i) m_v[i] = 0;
        end
        if (flush) m_ptr = 0;
        else if (g >= 0) m_ptr = (g + 1) % 3;
    endtask

    task automatic set_unit(input int i, input logic v, input logic [3:0] t, input logic [31:0] d);
        fu_valid[i]       = v;
        fu_tag[i*4 +: 4]  = t;
        fu_data[i*32 +: 32] = d;
    endtask

    task automatic clear_units();
        fu_valid = '0;
    endtask

    // One cycle: inputs already driven (at a falling edge); check ready, clock, check bus
    task automatic cycle(input logic fl);
        flush = fl;
        #1;
        check_val("fu_ready", fu_ready, model_ready());
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_val("cdb_valid", cdb_valid, m_cv);
        check_val("cdb_src", cdb_src, m_csrc);
        if (m_cv) begin
            check_val("cdb_tag", cdb_tag, m_ctag);
            check_val("cdb_data", cdb_data, m_cdata);
        end
        check_val("contention_cnt", contention_cnt, m_cnt);
        flush = 1'b0;
    endtask

    initial begin
        int seen, base;
        model_reset();

        // Reset then idle
        repeat (2) @(negedge clk);
        check_val("rst_cdb_valid", cdb_valid, 0);
        check_val("rst_fu_ready", fu_ready, 3'b111);
        check_val("rst_cnt", contention_cnt, 0);
        check_val("rst_cdb_tag", cdb_tag, 0);
        check_val("rst_cdb_data", cdb_data, 0);
        check_val("rst_cdb_src", cdb_src, 0);
        rst_n = 1'b1;
        repeat (3) cycle(0);

        // Single result from MUL
        set_unit(MUL, 1, 4'd5, 32'h0000_0010);
        cycle(0);
        clear_units();
        cycle(0);
        check_val("single_valid", cdb_valid, 1);
        check_val("single_tag", cdb_tag, 5);
        check_val("single_data", cdb_data, 32'h10);
        check_val("single_src", cdb_src, 3'b010);
        cycle(0);
        check_val("single_drop", cdb_valid, 0);

        // Three-way contention from pointer 0
        cycle(1);
        base = contention_cnt;
        set_unit(ADDSUB, 1, 4'd1, 32'hA1);
        set_unit(MUL,    1, 4'd2, 32'hB2);
        set_unit(DIV,    1, 4'd3, 32'hC3);
        cycle(0);
        clear_units();
        for (int k = 0; k < 3; k++) begin
            cycle(0);
            check_val("rr_order_tag", cdb_tag, k + 1);
            check_val("rr_order_valid", cdb_valid, 1);
        end
        check_val("contention_after", contention_cnt, base + 2);
        cycle(0);

        // Fairness: ADDSUB streams while DIV holds tag 9
        cycle(1);
        set_unit(DIV, 1, 4'd9, 32'h99);
        set_unit(ADDSUB, 1, 4'd1, 32'h100);
        cycle(0);
        set_unit(DIV, 0, 4'd0, 32'h0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            set_unit(ADDSUB, 1, 4'(2 + k), 32'h200 + k);
            cycle(0);
            if (cdb_valid && cdb_src == 3'b100 && cdb_tag == 4'd9) seen = 1;
        end
        check_val("div_not_starved", seen, 1);
        for (int k = 0; k < 4; k++) begin
            set_unit(ADDSUB, 1, 4'(1 + k), 32'h300 + k);
            cycle(0);
        end
        clear_units();
        repeat (2) cycle(0);

        // Backpressure and gap-free handover
        cycle(1);
        set_unit(MUL, 1, 4'd4, 32'h44);
        set_unit(DIV, 1, 4'd6, 32'h66);
        cycle(0);
        clear_units();
        set_unit(ADDSUB, 1, 4'd7, 32'h77);
        cycle(0);
        set_unit(ADDSUB, 1, 4'd8, 32'h88);
        #1;
        check_val("bp_ready_low", fu_ready[0], 0);
        cycle(0);
        #1;
        check_val("bp_ready_grant", fu_ready[0], 1);
        cycle(0);
        check_val("bp_tag7", cdb_tag, 7);
        set_unit(ADDSUB, 1, 4'd10, 32'hAA);
        cycle(0);
        check_val("bp_no_bubble_valid", cdb_valid, 1);
        check_val("bp_no_bubble_tag", cdb_tag, 8);
        clear_units();
        repeat (2) cycle(0);

        // Flush with all buffers loaded and a concurrent ADDSUB offer
        set_unit(ADDSUB, 1, 4'd1, 32'h1);
        set_unit(MUL,    1, 4'd2, 32'h2);
        set_unit(DIV,    1, 4'd3, 32'h3);
        cycle(0);
        clear_units();
        set_unit(ADDSUB, 1, 4'd11, 32'hBB);
        cycle(1);
        check_val("flush_valid", cdb_valid, 0);
        clear_units();
        cycle(0);
        check_val("flush_empty", cdb_valid, 0);
        set_unit(ADDSUB, 1, 4'd12, 32'hC);
        set_unit(MUL,    1, 4'd13, 32'hD);
        set_unit(DIV,    1, 4'd14, 32'hE);
        cycle(0);
        clear_units();
        cycle(0);
        check_val("flush_ptr0_src", cdb_src, 3'b001);
        repeat (3) cycle(0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++)
                set_unit(i, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
            cycle(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end
        clear_units();
        repeat (3) cycle(0);

        // Asynchronous reset in the middle of a broadcast
        set_unit(DIV, 1, 4'd15, 32'hF00D);
        cycle(0);
        clear_units();
        cycle(0);
        check_val("pre_rst_valid", cdb_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", cdb_valid, 0);
        check_val("async_rst_ready", fu_ready, 3'b111);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_val("post_rst_cnt", contention_cnt, 0);
        cycle(0);

        // Saturation of the contention counter
        for (int n = 0; n < 65600; n++) begin
            for (int i = 0; i < 3; i++)
                set_unit(i, 1'b1, 4'($urandom_range(1, 15)), $urandom);
            cycle(0);
        end
        check_val("cnt_saturated", contention_cnt, 16'hFFFF);
        cycle(1);
        check_val("cnt_kept_on_flush", contention_cnt, 16'hFFFF);
        clear_units();
        repeat (2) cycle(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single Common Data Bus (CDB) between the three functional units: add/sub, multiply and divide.
- Each unit hands over a completed result (reservation-station tag + value) through a valid/ready handshake. The result is held in a per-unit one-entry buffer.
- One buffered result per cycle is broadcast on a registered CDB, using round-robin priority.
- Sits between the FU outputs and the reservation stations / register status table, which snoop the CDB.

Parameters:
- NUM_FU, 3: number of requesting units. Index order equals the ALU-select encoding: 0 = add/sub, 1 = multiply, 2 = divide.
- DATA_W, 32: result width.
- TAG_W, 4: reservation-station tag width. Tag 0 is reserved as "no producer".
- CNT_W, 16: width of the contention counter.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all buffered results (e.g. on pipeline squash).
- fu_valid  in  NUM_FU  per-unit result valid.
- fu_tag  in  NUM_FU*TAG_W  per-unit result tag. Unit i occupies bits [i*TAG_W +: TAG_W].
- fu_data  in  NUM_FU*DATA_W  per-unit result value, packed the same way.
- fu_ready  out  NUM_FU  per-unit ready. A transfer happens when fu_valid[i] && fu_ready[i].
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast tag (registered).
- cdb_data  out  DATA_W  broadcast value (registered).
- cdb_src  out  NUM_FU  one-hot unit that owns the current broadcast (registered).
- contention_cnt  out  CNT_W  saturating count of cycles with two or more buffered results.

Behaviour:
- Reset values (asynchronous, rst_n low): all buffer valid bits 0, rr_ptr = 0, cdb_valid 0, cdb_tag 0, cdb_data 0, cdb_src 0, contention_cnt 0. fu_ready resets to all ones, since it is combinational from empty buffers.
- Buffers: per unit, buf_v[i], buf_tag[i], buf_data[i].
- Grant: combinational, among i with buf_v[i]. Search starts at rr_ptr and wraps modulo NUM_FU; the first set index wins. At most one grant per cycle.
- Ready: fu_ready[i] = !buf_v[i] || grant[i]. A buffer draining this cycle may accept a new result in the same cycle, which gives full throughput with no bubble.
- Buffer update per cycle, in priority order:
  - flush: buf_v <= 0, regardless of accept or grant.
  - accept: buf_v[i] <= 1, and tag/data are captured.
  - grant without accept: buf_v[i] <= 0.
- Broadcast register: each cycle, cdb_valid <= |grant && !flush. On a grant, cdb_tag/cdb_data/cdb_src take the granted buffer contents. cdb_src <= 0 when cdb_valid goes to 0. cdb_tag/cdb_data hold their last value when not valid, and are don't-care for consumers.
- Latency: a result accepted at edge N is broadcast (cdb_valid high) at the earliest after edge N+1, i.e. one cycle in the buffer, then registered out.
- rr_ptr: after a grant to unit g, rr_ptr <= (g+1) mod NUM_FU. Unchanged when there is no grant. Reset to 0 on flush.
- Fairness bound: a buffered result waits at most NUM_FU-1 cycles before broadcast.
- Tag-0 input: an fu_valid with tag 0 is accepted and broadcast unchanged. Checking is the responsibility of the issuing side, via a simulation-only assertion.
- contention_cnt: increments when popcount(buf_v) >= 2 and flush is low. It saturates at all ones and never wraps. It is not cleared by flush, only by reset.
- Reset mid-operation: all buffered results are discarded immediately and cdb_valid drops asynchronously.
- No combinational path exists from fu_valid to cdb_* outputs. fu_ready depends only on state, not on fu_valid.

Decomposition:
- Shared header: NUM_FU and the unit index constants (ADDSUB = 0, MUL = 1, DIV = 2, aligned with the existing ALU-select constants), TAG_W, DATA_W, and the TAG_NONE = 0 constant.
- One sub-module: rr_pick (NUM_FU-wide round-robin priority picker). Inputs are the request vector and pointer; outputs are the one-hot grant and the encoded index. It is reusable for issue selection inside reservation stations.

Test Plan:
- Reset then idle:
  - hold rst_n low for 2 cycles, then high with fu_valid = 0 → cdb_valid = 0, fu_ready = 3'b111, contention_cnt = 0 throughout.
- Single result:
  - MUL offers tag 5, data 32'h0000_0010 at edge N → fu_ready[1] = 1 at N.
  - After edge N+1: cdb_valid = 1, tag 5, data 0x10, cdb_src = 3'b010.
  - After edge N+2: cdb_valid = 0.
- Three-way contention:
  - all units valid in the same cycle (tags 1, 2, 3), rr_ptr = 0 → broadcasts tag 1, 2, 3 on three consecutive cycles.
  - contention_cnt = 2 after the sequence.
- Round-robin fairness:
  - ADDSUB offers a new result every cycle while DIV holds tag 9.
  - DIV tag 9 is broadcast within 2 cycles of buffering.
  - Grants alternate ADDSUB/DIV, with no starvation.
- Backpressure and full throughput:
  - ADDSUB buffer occupied and not granted → fu_ready[0] = 0 while fu_valid[0] is held.
  - In the cycle of its grant, fu_ready[0] = 1, and the next result is accepted with no idle bus cycle.
- Flush and async reset:
  - Load all three buffers, assert flush for 1 cycle together with a new ADDSUB offer → next cycle cdb_valid = 0, all buffers empty, rr_ptr = 0.
  - Assert rst_n low mid-broadcast → cdb_valid falls before the next clock edge.
